riscv_rf_wb_arbiter: RTL and testbench



---
 rtl/riscv_rf_wb_pkg.sv | 12 +
 rtl/riscv_rf_wb_rr_arb.sv | 43 ++++
 rtl/riscv_rf_wb_arbiter.sv | 95 +++++++++
 tb/tb_riscv_rf_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_wb_pkg.sv
// riscv_rf_wb_pkg: shared constants, writeback request type and address normalisation
package riscv_rf_wb_pkg;
  localparam int INT_WORDS = 32;
  localparam int FP_WORDS = 32;
  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wb_req_t;
  function automatic logic [5:0] eff_addr(input logic [5:0] addr, input logic fp_ena);
    return {addr[5] & fp_ena, addr[4:0]};
  endfunction
endpackage

// File: rtl/riscv_rf_wb_rr_arb.sv
// riscv_rf_wb_rr_arb: round-robin dual-grant picker, port B first, port A must differ in address
module riscv_rf_wb_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int AW = 6,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    valid,
  input  logic [NUM_REQ*AW-1:0] addr,
  output logic [NUM_REQ-1:0]    ready,
  output logic                  gnt_b,
  output logic                  gnt_a,
  output logic [IW-1:0]         idx_b,
  output logic [IW-1:0]         idx_a
);
  logic [IW-1:0] rr_ptr, last, rr_nxt;
  always_comb begin
    ready = '0;
    gnt_b = 1'b0;
    gnt_a = 1'b0;
    idx_b = '0;
    idx_a = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (int'(rr_ptr) + k) % NUM_REQ;
      if (valid[i] && !gnt_b) begin
        gnt_b = 1'b1;
        idx_b = IW'(i);
        ready[i] = 1'b1;
      end else if (valid[i] && !gnt_a && addr[i*AW +: AW] != addr[idx_b*AW +: AW]) begin
        gnt_a = 1'b1;
        idx_a = IW'(i);
        ready[i] = 1'b1;
      end
    end
  end
  assign last = gnt_a ? idx_a : idx_b;
  assign rr_nxt = (last == IW'(NUM_REQ - 1)) ? '0 : last + IW'(1);
  always_ff @(posedge clk)
    if (rst) rr_ptr <= '0;
    else if (gnt_b) rr_ptr <= rr_nxt;
endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// riscv_rf_wb_arbiter: round-robin writeback onto two RF write ports with busy-bit scoreboard and RAW hazard flags
module riscv_rf_wb_arbiter
  import riscv_rf_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int FPU = 1,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fregfile_disable_i,
  input  logic                           issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]          issue_addr_i,
  output logic                           issue_ready_o,
  input  logic [ADDR_WIDTH-1:0]          raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]          raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]          raddr_c_i,
  output logic                           hazard_a_o,
  output logic                           hazard_b_o,
  output logic                           hazard_c_o,
  input  logic [NUM_REQ-1:0]             wb_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wb_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wb_data_i,
  output logic [NUM_REQ-1:0]             wb_ready_o,
  output logic [ADDR_WIDTH-1:0]          waddr_a_o,
  output logic [DATA_WIDTH-1:0]          wdata_a_o,
  output logic                           we_a_o,
  output logic [ADDR_WIDTH-1:0]          waddr_b_o,
  output logic [DATA_WIDTH-1:0]          wdata_b_o,
  output logic                           we_b_o
);
  localparam int SB_WORDS = FPU != 0 ? INT_WORDS + FP_WORDS : INT_WORDS;
  localparam int SB_AW = $clog2(SB_WORDS);
  logic fp_ena;
  logic [ADDR_WIDTH-1:0] iss_eff, ra_eff, rb_eff, rc_eff;
  logic [SB_WORDS-1:0] busy, busy_nxt;
  wb_req_t [NUM_REQ-1:0] req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_eff;
  wb_req_t sel_a, sel_b;
  logic gnt_a, gnt_b;
  logic [IW-1:0] idx_a, idx_b;
  assign fp_ena = (FPU != 0) & ~fregfile_disable_i;
  assign iss_eff = eff_addr(issue_addr_i, fp_ena);
  assign ra_eff = eff_addr(raddr_a_i, fp_ena);
  assign rb_eff = eff_addr(raddr_b_i, fp_ena);
  assign rc_eff = eff_addr(raddr_c_i, fp_ena);
  assign issue_ready_o = ~busy[iss_eff[SB_AW-1:0]] | (iss_eff == '0);
  assign hazard_a_o = busy[ra_eff[SB_AW-1:0]];
  assign hazard_b_o = busy[rb_eff[SB_AW-1:0]];
  assign hazard_c_o = busy[rc_eff[SB_AW-1:0]];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req[i] = {eff_addr(wb_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH], fp_ena), wb_data_i[i*DATA_WIDTH +: DATA_WIDTH]};
    assign req_eff[i*ADDR_WIDTH +: ADDR_WIDTH] = req[i].addr;
  end
  riscv_rf_wb_rr_arb #(.NUM_REQ(NUM_REQ), .AW(ADDR_WIDTH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (wb_valid_i),
    .addr  (req_eff),
    .ready (wb_ready_o),
    .gnt_b (gnt_b),
    .gnt_a (gnt_a),
    .idx_b (idx_b),
    .idx_a (idx_a)
  );
  assign sel_a = req[idx_a];
  assign sel_b = req[idx_b];
  always_comb begin
    busy_nxt = busy;
    if (we_a_o) busy_nxt[waddr_a_o[SB_AW-1:0]] = 1'b0;
    if (we_b_o) busy_nxt[waddr_b_o[SB_AW-1:0]] = 1'b0;
    if (issue_valid_i && issue_ready_o && iss_eff != '0) busy_nxt[iss_eff[SB_AW-1:0]] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_o <= 1'b0;
      we_b_o <= 1'b0;
      waddr_a_o <= '0;
      waddr_b_o <= '0;
      wdata_a_o <= '0;
      wdata_b_o <= '0;
      busy <= '0;
    end else begin
      we_a_o <= gnt_a & (sel_a.addr != '0);
      we_b_o <= gnt_b & (sel_b.addr != '0);
      waddr_a_o <= sel_a.addr;
      waddr_b_o <= sel_b.addr;
      wdata_a_o <= sel_a.data;
      wdata_b_o <= sel_b.data;
      busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// tb_riscv_rf_wb_arbiter: randomized scoreboard bench against a behavioural writeback/scoreboard model
module tb_riscv_rf_wb_arbiter;
  localparam int N = 4, AW = 6, DW = 32;
  logic clk = 0;
  logic rst = 1;
  logic fregfile_disable_i = 0, issue_valid_i = 0, issue_ready_o;
  logic [AW-1:0] issue_addr_i = '0, raddr_a_i = '0, raddr_b_i = '0, raddr_c_i = '0;
  logic hazard_a_o, hazard_b_o, hazard_c_o;
  logic [N-1:0] wb_valid_i = '0, wb_ready_o;
  logic [N*AW-1:0] wb_addr_i = '0;
  logic [N*DW-1:0] wb_data_i = '0;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;
  logic we_a_o, we_b_o;
  always #5 clk = ~clk;
  riscv_rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .fregfile_disable_i(fregfile_disable_i),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i), .issue_ready_o(issue_ready_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o), .hazard_c_o(hazard_c_o),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_ready_o(wb_ready_o),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o)
  );
  typedef struct { bit vld; bit [N-1:0] rdy; bit irdy; bit [2:0] haz; } comb_t;
  typedef struct { bit vld; bit we_a; bit we_b; bit [5:0] a_a; bit [5:0] a_b; bit [31:0] d_a; bit [31:0] d_b; } wr_t;
  comb_t comb_q[$];
  wr_t wr_q[$];
  int compared = 0, mismatched = 0;
  bit busy [64];
  int rr = 0;
  wr_t live;
  bit started = 0;
  bit r = 1, iv = 0, fdis = 0;
  bit [5:0] ia = 0;
  bit [5:0] ra [3];
  bit pend [N];
  bit [5:0] paddr [N];
  bit [31:0] pdata [N];
  bit [5:0] pool [8] = '{6'h00, 6'h01, 6'h02, 6'h05, 6'h07, 6'h21, 6'h25, 6'h05};
  function automatic bit [5:0] eff(bit [5:0] a);
    return {a[5] & ~fdis, a[4:0]};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic step();
    comb_t c;
    wr_t w;
    int b, a;
    @(negedge clk);
    rst = r;
    fregfile_disable_i = fdis;
    issue_valid_i = iv;
    issue_addr_i = ia;
    raddr_a_i = ra[0];
    raddr_b_i = ra[1];
    raddr_c_i = ra[2];
    for (int i = 0; i < N; i++) begin
      wb_valid_i[i] = pend[i] & ~r;
      wb_addr_i[i*AW +: AW] = paddr[i];
      wb_data_i[i*DW +: DW] = pdata[i];
    end
    #1;
    c = '{default: 0};
    w = '{default: 0};
    c.vld = started;
    w.vld = 1;
    c.irdy = eff(ia) == 0 || !busy[eff(ia)];
    for (int k = 0; k < 3; k++) c.haz[k] = busy[eff(ra[k])];
    b = -1;
    a = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (pend[i] && !r) begin
        if (b < 0) b = i;
        else if (a < 0 && eff(paddr[i]) != eff(paddr[b])) a = i;
      end
    end
    if (b >= 0) begin
      c.rdy[b] = 1;
      w.we_b = eff(paddr[b]) != 0;
      w.a_b = eff(paddr[b]);
      w.d_b = pdata[b];
    end
    if (a >= 0) begin
      c.rdy[a] = 1;
      w.we_a = eff(paddr[a]) != 0;
      w.a_a = eff(paddr[a]);
      w.d_a = pdata[a];
    end
    comb_q.push_back(c);
    wr_q.push_back(w);
    if (r) begin
      foreach (busy[i]) busy[i] = 0;
      rr = 0;
    end else begin
      if (live.we_a) busy[live.a_a] = 0;
      if (live.we_b) busy[live.a_b] = 0;
      if (iv && c.irdy && eff(ia) != 0) busy[eff(ia)] = 1;
      if (b >= 0) begin
        rr = ((a >= 0 ? a : b) + 1) % N;
        pend[b] = 0;
        if (a >= 0) pend[a] = 0;
      end
    end
    live = w;
    started = 1;
  endtask
  task automatic go(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic req(int i, bit [5:0] ad, bit [31:0] d);
    pend[i] = 1;
    paddr[i] = ad;
    pdata[i] = d;
  endtask
  always @(negedge clk) begin
    #2;
    if (comb_q.size() != 0 && wr_q.size() != 0) begin
      comb_t c;
      wr_t w;
      c = comb_q.pop_front();
      w = wr_q.pop_front();
      if (c.vld) begin
        chk("wb_ready", 64'(wb_ready_o), 64'(c.rdy));
        chk("issue_ready", 64'(issue_ready_o), 64'(c.irdy));
        chk("hazards", 64'({hazard_c_o, hazard_b_o, hazard_a_o}), 64'(c.haz));
      end
      if (w.vld) begin
        chk("we_a", 64'(we_a_o), 64'(w.we_a));
        chk("we_b", 64'(we_b_o), 64'(w.we_b));
        if (w.we_a) begin
          chk("waddr_a", 64'(waddr_a_o), 64'(w.a_a));
          chk("wdata_a", 64'(wdata_a_o), 64'(w.d_a));
        end
        if (w.we_b) begin
          chk("waddr_b", 64'(waddr_b_o), 64'(w.a_b));
          chk("wdata_b", 64'(wdata_b_o), 64'(w.d_b));
        end
      end
    end
  end
  initial begin
    wr_t w0;
    w0 = '{default: 0};
    wr_q.push_back(w0);
    live = w0;
    foreach (busy[i]) busy[i] = 0;
    foreach (pend[i]) pend[i] = 0;
    foreach (ra[i]) ra[i] = 0;
    go(2);
    r = 0;
    iv = 1; ia = 6'd5; ra[0] = 6'd5;
    step();
    iv = 0;
    step();
    req(2, 6'd5, 32'hDEADBEEF);
    go(3);
    req(1, 6'd9, 32'h1234_5678);
    step();
    r = 1;
    step();
    r = 0;
    go(2);
    req(0, 6'd1, 32'h11); req(1, 6'd2, 32'h22); req(3, 6'd3, 32'h33);
    go(4);
    req(0, 6'd7, 32'h70); req(1, 6'd7, 32'h71);
    go(4);
    iv = 1; ia = 6'd5;
    step();
    step();
    iv = 0;
    req(0, 6'd6, 32'h66);
    step();
    iv = 1; ia = 6'd6; ra[1] = 6'd6;
    step();
    iv = 0;
    go(2);
    fdis = 1; ra[2] = 6'h25;
    req(3, 6'h25, 32'hF00D);
    go(3);
    req(2, 6'd0, 32'hAAAA);
    go(2);
    fdis = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) req(i, pool[$urandom_range(7, 0)], $urandom);
      iv = $urandom_range(1, 0) == 1;
      ia = pool[$urandom_range(7, 0)];
      for (int k = 0; k < 3; k++) ra[k] = pool[$urandom_range(7, 0)];
      if ($urandom_range(31, 0) == 0) fdis = ~fdis;
      r = $urandom_range(511, 0) == 0;
      step();
    end
    r = 0; iv = 0;
    foreach (pend[i]) pend[i] = 0;
    go(3);
    repeat (2) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
